// File: rtl/msk_ct_unshare_serializer_if.sv
// ----------------------------------------------------------------------------
// msk_ct_unshare_serializer_if
// Purpose : bundles the core-side ciphertext handshake and the 32-bit word
//           stream of msk_ct_unshare_serializer into one interface.
// Signals :
//   sh_ciphertext [128*D] shared ciphertext, share s of bit i at index D*i+s
//   cipher_valid          core output valid
//   out_ready             ready back toward the core
//   word_data     [32]    recombined ciphertext word
//   word_valid            word stream valid
//   word_ready            downstream ready
//   word_last             marks the 4th beat of a block
// Modports: master = core/downstream side (drives inputs of the serializer),
//           slave  = the serializer itself.
// ----------------------------------------------------------------------------
interface msk_ct_unshare_serializer_if #(
    parameter int D = 2
);
    logic [128*D-1:0] sh_ciphertext;
    logic             cipher_valid;
    logic             out_ready;
    logic [31:0]      word_data;
    logic             word_valid;
    logic             word_ready;
    logic             word_last;

    modport master (
        output sh_ciphertext, cipher_valid, word_ready,
        input  out_ready, word_data, word_valid, word_last
    );

    modport slave (
        input  sh_ciphertext, cipher_valid, word_ready,
        output out_ready, word_data, word_valid, word_last
    );
endinterface

// File: rtl/msk_ct_unshare_serializer.sv
// ----------------------------------------------------------------------------
// msk_ct_unshare_serializer
// Purpose : takes a d-share masked 128-bit ciphertext from the masked AES core,
//           XOR-recombines the shares into the public ciphertext and streams it
//           out as four 32-bit beats (low word first). The ciphertext register
//           is cleared once the last beat is taken with no follow-up block.
// Ports   :
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of msk_ct_unshare_serializer_if (core handshake and
//          word stream)
//   busy   out  high while a block is held (SEND)
// Parameters:
//   d              number of shares, must match the core and the interface D
//   REVERSE_BYTES  1 = byte-swap each beat (big-endian FIPS-197 byte order)
// ----------------------------------------------------------------------------
module msk_ct_unshare_serializer #(
    parameter int d             = 2,
    parameter bit REVERSE_BYTES = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    msk_ct_unshare_serializer_if.slave    bus,
    output logic                          busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t       r_state;
    logic [127:0] r_ct;
    logic [1:0]   r_beat;

    logic [127:0] w_ct;
    logic [31:0]  w_word_raw;
    logic [31:0]  w_word;
    logic         w_send;
    logic         w_last_accept;
    logic         w_take;

    // Share recombination: pure XOR, no fresh randomness involved.
    always_comb begin
        w_ct = '0;
        for (int i = 0; i < 128; i++) begin
            for (int s = 0; s < d; s++) begin
                w_ct[i] = w_ct[i] ^ bus.sh_ciphertext[d*i+s];
            end
        end
    end

    assign w_send        = (r_state == S_SEND);
    assign w_last_accept = w_send && (r_beat == 2'd3) && bus.word_ready;

    // The only combinational ready path: the core may hand over the next
    // block in the very cycle the final beat leaves, giving gapless streaming.
    assign bus.out_ready = (r_state == S_IDLE) || w_last_accept;
    assign w_take        = bus.out_ready && bus.cipher_valid;

    assign w_word_raw = r_ct[32*r_beat +: 32];
    assign w_word     = REVERSE_BYTES ? {w_word_raw[7:0],   w_word_raw[15:8],
                                         w_word_raw[23:16], w_word_raw[31:24]}
                                      : w_word_raw;

    // Data is gated so nothing of the ciphertext is visible outside SEND.
    assign bus.word_valid = w_send;
    assign bus.word_data  = w_send ? w_word : 32'd0;
    assign bus.word_last  = w_send && (r_beat == 2'd3);
    assign busy           = w_send;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ct    <= '0;
            r_beat  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_ct    <= w_ct;
                        r_beat  <= 2'd0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.word_ready) begin
                        if (r_beat != 2'd3) begin
                            r_beat <= r_beat + 2'd1;
                        end else if (bus.cipher_valid) begin
                            // back-to-back block, no bubble
                            r_ct   <= w_ct;
                            r_beat <= 2'd0;
                        end else begin
                            // zeroize once the block has fully left
                            r_ct    <= '0;
                            r_beat  <= 2'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ct    <= '0;
                    r_beat  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/msk_ct_unshare_serializer.md
# msk_ct_unshare_serializer

Output-side companion of `MSKaes_32bits_core`. It accepts a shared 128-bit ciphertext from the core over the core's `cipher_valid`/`out_ready` handshake and recombines the shares (XOR) into the public ciphertext. It then streams the result as four 32-bit words over a valid/ready/last interface to a bus bridge or FIFO. After the last word is delivered, the internal ciphertext register is zeroized.

## Interface
Parameters:
- `d`, 2: number of shares (≥2); must match the core.
- `REVERSE_BYTES`, 0: if 1, the 4 bytes of each output word are swapped, so beat 0 equals FIPS-197 bytes 0..3 in big-endian order.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sh_ciphertext`  in  128*d  shared ciphertext in shbus encoding; share s of bit i is at index d*i+s.
- `cipher_valid`  in  1  core output valid.
- `out_ready`  out  1  ready toward the core; combinational, see Operation.
- `word_data`  out  32  recombined ciphertext word.
- `word_valid`  out  1  word stream valid.
- `word_ready`  in  1  downstream ready.
- `word_last`  out  1  marks beat 3 of a block.
- `busy`  out  1  block held (state SEND).

## Operation
- Recombination: `ct[i] = XOR over s=0..d-1 of sh_ciphertext[d*i+s]`. Purely combinational into the capture register; no randomness is consumed.
- States: IDLE and SEND. Registers: `ct_reg[127:0]`, `beat[1:0]`, state.
- IDLE:
  - `out_ready=1`, `word_valid=0`.
  - If `cipher_valid`: `ct_reg <= ct`, `beat <= 0`, go to SEND.
- SEND:
  - `word_valid=1`.
  - `word_data = ct_reg[32*beat +: 32]`, byte-swapped if `REVERSE_BYTES`.
  - `word_last = (beat==3)`.
  - On `word_ready`: if `beat<3`, `beat <= beat+1`.
  - On `word_ready` with `beat==3`, one of two things happens:
    - If `cipher_valid`: capture the new block, `beat <= 0`, stay in SEND (back-to-back).
    - Otherwise: `ct_reg <= 0`, go to IDLE.
- `out_ready = (state==IDLE) | (state==SEND & beat==3 & word_ready)`. This is the only combinational ready path.
- `word_data` is forced to 0 whenever `word_valid=0`; ciphertext is never exposed outside SEND.
- `word_valid` stays high until accepted; `word_data` and `word_last` are stable while `word_valid & !word_ready`.
- `cipher_valid` high while `out_ready=0` has no effect; the block is taken when `out_ready` rises.
- `busy = (state==SEND)`.
- Reset is asynchronous at any time, including mid-block: state goes to IDLE, `ct_reg=0`, `beat=0`. The pending block is dropped with no partial continuation.

## Timing
- Reset values:
  - `word_valid=0`, `word_last=0`, `word_data=0`, `busy=0`.
  - `out_ready=1` (IDLE).
- Latency: block captured on edge N; beat 0 is valid in the cycle after edge N.
- Throughput:
  - With `word_ready` held at 1 and `cipher_valid` held at 1: one block per 4 cycles, no bubble.
  - Isolated block: 4 beat cycles, then IDLE.
- Back-pressure: each cycle with `word_ready=0` in SEND adds exactly one cycle. The core is stalled through `out_ready=0`.
- After the last beat is accepted with no new block, the cycle after that edge shows IDLE, `ct_reg=0`, `out_ready=1`.

## Test plan
- **Basic block.**
  - Stimulus: d=2, share0 = `128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469 ^ M`, share1 = M (random M), pulse `cipher_valid`, `word_ready=1`.
  - Required: beats `d8e0c469`, `30047b6a`, `80b7cdd8`, `5ac5b470`, with `word_last` only on the 4th beat; `ct_reg==0` afterwards.
- **Byte order.**
  - Stimulus: same block with `REVERSE_BYTES=1`.
  - Required: beats `69c4e0d8`, `6a7b0430`, `d8cdb780`, `70b4c55a`.
- **Back-pressure.**
  - Stimulus: `word_ready` random (50%).
  - Required: no beat lost or duplicated; data is stable while stalled; `out_ready=0` throughout SEND except in the last-beat-accept cycle.
- **Back-to-back.**
  - Stimulus: two blocks with `cipher_valid` held and `word_ready=1`, d=3.
  - Required: 8 consecutive valid beats with no gap; the second block is captured in the cycle beat 3 of the first is accepted.
- **Reset mid-block.**
  - Stimulus: assert `rst_n=0` asynchronously after beat 1.
  - Required: `word_valid` drops immediately; after release, `out_ready=1`, `word_data=0`, and no remaining beats of the old block appear.
- **Idle leakage.**
  - Stimulus: `cipher_valid=0` for 100 cycles after a block.
  - Required: `word_data==0` and `word_valid==0` throughout.
